mmio_write_buffer: RTL and testbench

- Memory-mapped store buffer on the CPU data-memory port, alongside data memory, at the MEM-stage bus (address, store data, store-width control, read strobe).
- Captures CPU stores whose address falls inside a peripheral window and queues them in a FIFO with byte enables.
- Drains the queue to the mixer peripheral bus over a valid/ready handshake, so peripheral latency never stalls the pipeline.
- A status word in the window reports queue level and a sticky overflow flag.

---
 rtl/mmio_write_buffer.sv | 136 +++++++++++++
 tb/tb_mmio_write_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_write_buffer.sv
// rtl/mmio_write_buffer.sv - MMIO store buffer FIFO draining to the mixer bus; MMIO_WRBUF_STATUS_EN adds a status register
module mmio_write_buffer #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          WIN_BITS  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              Daddr,
  input  logic [31:0]              Dout,
  input  logic [1:0]               DMC,
  input  logic                     Dread,
  output logic                     hit,
  output logic [31:0]              rdata,
  output logic                     p_valid,
  output logic [WIN_BITS-3:0]      p_addr,
  output logic [31:0]              p_data,
  output logic [3:0]               p_be,
  input  logic                     p_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int AW = WIN_BITS - 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          p_valid_q, p_valid_d;
  entry_t        head_q, head_d;

  logic          status_hit;
  logic          store_req;
  logic          enq;
  logic          deq;
  logic          drop;
  entry_t        new_entry;

  // Loads have no side effect on the queue; the strobe is intentionally unused.
  logic unused_dread;
  assign unused_dread = Dread;

  assign hit = (Daddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);

`ifdef MMIO_WRBUF_STATUS_EN
  assign status_hit = hit && (Daddr[WIN_BITS-1:2] == {AW{1'b1}});
  assign rdata      = status_hit ? {overflow_q, 15'b0, {(16-LW){1'b0}}, level_q} : 32'h0;
`else
  assign status_hit = 1'b0;
  assign rdata      = 32'h0;
`endif

  // Classify the MEM-stage access and format the store into byte lanes
  always_comb begin
    store_req      = hit && (DMC != 2'b00) && !status_hit;
    enq            = store_req && (level_q < LW'(DEPTH));
    drop           = store_req && (level_q == LW'(DEPTH));
    deq            = p_valid_q && p_ready;
    new_entry.addr = Daddr[WIN_BITS-1:2];
    new_entry.data = Dout;
    new_entry.be   = 4'b1111;
    case (DMC)
      2'b01: begin
        new_entry.be   = 4'b0001 << Daddr[1:0];
        new_entry.data = {4{Dout[7:0]}};
      end
      2'b10: begin
        new_entry.be   = Daddr[1] ? 4'b1100 : 4'b0011;
        new_entry.data = {2{Dout[15:0]}};
      end
      default: begin
        new_entry.be   = 4'b1111;
        new_entry.data = Dout;
      end
    endcase
  end

  // Next pointers, level, sticky flag and prefetched head entry
  always_comb begin
    rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    level_d    = level_q;
    if (enq && !deq) level_d = level_q + LW'(1);
    if (!enq && deq) level_d = level_q - LW'(1);
    overflow_d = overflow_q;
    if (status_hit && (DMC != 2'b00)) overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;
    p_valid_d  = (level_d != '0);
    // The slot being written this cycle becomes the head only when it is the sole entry.
    if (!p_valid_d) head_d = '0;
    else if (enq && (wr_ptr_q == rd_ptr_d)) head_d = new_entry;
    else head_d = mem_q[rd_ptr_d];
  end

  // Control state and registered head outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      p_valid_q  <= 1'b0;
      head_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      p_valid_q  <= p_valid_d;
      head_q     <= head_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= new_entry;
  end

  assign p_valid  = p_valid_q;
  assign p_addr   = head_q.addr;
  assign p_data   = head_q.data;
  assign p_be     = head_q.be;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mmio_write_buffer.sv
// tb/tb_mmio_write_buffer.sv - self-checking bench for mmio_write_buffer against a queue model
module tb_mmio_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Daddr, Dout, rdata, p_data;
  logic [1:0]  DMC;
  logic        Dread, hit, p_valid, p_ready, overflow;
  logic [9:0]  p_addr;
  logic [3:0]  p_be;
  logic [4:0]  level;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t m_q[$];
  bit   m_ovf;

  mmio_write_buffer dut (
    .clk(clk), .reset(reset), .Daddr(Daddr), .Dout(Dout), .DMC(DMC), .Dread(Dread),
    .hit(hit), .rdata(rdata), .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
    .p_be(p_be), .p_ready(p_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] dmc);
    ent_t e;
    e.a = addr[11:2];
    if (dmc == 2'd1) begin
      e.be = 4'(1 << (addr % 4));
      e.d  = {24'h0, d[7:0]} * 32'h0101_0101;
    end else if (dmc == 2'd2) begin
      e.be = (addr & 32'd2) != 0 ? 4'hC : 4'h3;
      e.d  = {16'h0, d[15:0]} * 32'h0001_0001;
    end else begin
      e.be = 4'hF;
      e.d  = d;
    end
    return e;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >> 12) == (BASE >> 12);
  endfunction

  function automatic bit is_status(input logic [31:0] a);
`ifdef MMIO_WRBUF_STATUS_EN
    return in_win(a) && ((a & 32'hFFF) == 32'hFFC);
`else
    return 1'b0;
`endif
  endfunction

  // Model: pop on handshake, push if room by pre-edge occupancy, else flag overflow
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      int  pre;
      pre = m_q.size();
      if (pre != 0 && p_ready) void'(m_q.pop_front());
      if (in_win(Daddr) && DMC != 2'b00 && !is_status(Daddr)) begin
        if (pre < 16) m_q.push_back(mk(Daddr, Dout, DMC));
        else m_ovf = 1'b1;
      end
      if (is_status(Daddr) && DMC != 2'b00) m_ovf = 1'b0;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    exp_rd = 32'h0;
    if (is_status(Daddr)) exp_rd = {m_ovf, 31'(m_q.size())};
    chk("p_valid", p_valid, m_q.size() != 0);
    chk("level", level, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("hit", hit, in_win(Daddr));
    chk("rdata", rdata, exp_rd);
    if (m_q.size() != 0) begin
      chk("p_addr", p_addr, m_q[0].a);
      chk("p_data", p_data, m_q[0].d);
      chk("p_be", p_be, m_q[0].be);
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] dmc);
    Daddr = a;
    Dout  = d;
    DMC   = dmc;
    @(posedge clk);
    #1;
    DMC   = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Daddr = 32'h0; Dout = 32'h0; DMC = 2'b00; Dread = 1'b0; p_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_p_valid", p_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_p_addr", p_addr, 0);
    chk("rst_p_data", p_data, 0);
    chk("rst_p_be", p_be, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    store(BASE + 32'h10, 32'hDEAD_BEEF, 2'b11); #2;
    chk("word_valid", p_valid, 1);
    chk("word_addr", p_addr, 4);
    chk("word_be", p_be, 4'b1111);
    chk("word_data", p_data, 32'hDEAD_BEEF);
    @(posedge clk); #3;
    chk("word_drained_valid", p_valid, 0);
    chk("word_drained_level", level, 0);

    store(BASE + 32'h23, 32'h0000_00A5, 2'b01); #2;
    chk("byte_addr", p_addr, 8);
    chk("byte_be", p_be, 4'b1000);
    chk("byte_data", p_data, 32'hA5A5_A5A5);
    @(posedge clk); #3;

    store(BASE + 32'h06, 32'h0000_1234, 2'b10); #2;
    chk("half_be", p_be, 4'b1100);
    chk("half_data", p_data, 32'h1234_1234);
    @(posedge clk); #3;

    store(32'h0000_0010, 32'h55, 2'b11); #2;
    chk("outside_level", level, 0);
    Daddr = BASE + 32'h20; Dread = 1'b1;
    @(posedge clk); #1;
    Dread = 1'b0;
    chk("load_level", level, 0);

    p_ready = 1'b0;
    for (int i = 0; i < 17; i++) store(BASE + 32'(4 * i), 32'h1000 + 32'(i), 2'b11);
    #2;
    chk("bp_level", level, 16);
    chk("bp_overflow", overflow, 1);
    chk("bp_head_data", p_data, 32'h1000);
    p_ready = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("bp_drained", level, 0);

    for (int i = 0; i < 20; i++) begin
      p_ready = i[0];
      store(BASE + 32'h100 + 32'(4 * i) + 32'(i % 4), 32'h0101_0101 * 32'(i + 1), 2'(1 + i % 3));
    end
    p_ready = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    chk("wrap_drained", level, 0);

    p_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(BASE + 32'h40 + 32'(4 * i), 32'(i), 2'b11);
    Daddr = BASE + 32'hFFC; Dread = 1'b1; #2;
`ifdef MMIO_WRBUF_STATUS_EN
    chk("status_rdata", rdata, 32'h8000_0003);
`else
    chk("status_rdata", rdata, 32'h0);
`endif
    Dread = 1'b0;
    store(BASE + 32'hFFC, 32'h0, 2'b11); #2;
`ifdef MMIO_WRBUF_STATUS_EN
    chk("status_clr_ovf", overflow, 0);
    chk("status_clr_level", level, 3);
`else
    chk("status_plain_ovf", overflow, 1);
    chk("status_plain_level", level, 4);
`endif
    p_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    p_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(BASE + 32'h80 + 32'(4 * i), 32'hA000 + 32'(i), 2'b11);
    #2;
    chk("pre_rst_valid", p_valid, 1);
    chk("pre_rst_level", level, 5);
    @(posedge clk); #1;
    p_ready = 1'b1;
    reset = 1'b0; #1;
    chk("mid_rst_valid", p_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_overflow", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_valid", p_valid, 0);
    chk("post_rst_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
